// File: rtl/instr_mem_pkg.sv
// Shared constants for the instruction fetch memory: the boot image and helpers.
package instr_mem_pkg;

  localparam int BOOT_LEN = 7;

  // add r3,r3; sll r3,1; add r3,r3; j L1; sll r3,3; add r7,r3; nop
  localparam logic [7:0] BOOT_IMAGE [BOOT_LEN] = '{
    8'h1B, 8'h59, 8'h1B, 8'hC5, 8'h5B, 8'h3B, 8'h00
  };

  localparam logic [7:0] NOP_INSTR = 8'h00;

  function automatic int instr_w(input int instr_bytes);
    return 8 * instr_bytes;
  endfunction

endpackage

// File: rtl/instr_byte_ram.sv
// DEPTH x 8 byte store: one write port, a parallel boot-image write, and
// INSTR_BYTES asynchronous read taps starting at a base byte address.
module instr_byte_ram
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 36,
  parameter int INSTR_BYTES = 4,
  parameter int IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     boot_i,
  input  logic                     we_i,
  input  logic [IDX_W-1:0]         waddr_i,
  input  logic [7:0]               wdata_i,
  input  logic [ADDR_W:0]          raddr_i,
  output logic [8*INSTR_BYTES-1:0] rdata_o
);

  logic [7:0] mem [DEPTH];

  // Boot has priority; the top never raises we_i while boot_i is high.
  always_ff @(posedge clk) begin
    if (boot_i) begin
      for (int i = 0; i < BOOT_LEN; i++) begin
        if (i < DEPTH) mem[IDX_W'(i)] <= BOOT_IMAGE[i];
      end
    end else if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  for (genvar k = 0; k < INSTR_BYTES; k++) begin : g_tap
    logic [ADDR_W:0] tap_addr;
    assign tap_addr = raddr_i + (ADDR_W+1)'(k);
    // Taps past the end read as zero; such fetches fault and are masked anyway.
    assign rdata_o[8*k +: 8] = (tap_addr < (ADDR_W+1)'(DEPTH)) ?
                               mem[tap_addr[IDX_W-1:0]] : 8'h00;
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// Byte-addressable instruction memory with a registered, valid/ready fetch
// port, a byte program-load port and fault reporting.
module instr_fetch_mem
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 36,
  parameter int INSTR_BYTES = 4,
  parameter bit ALIGN_CHK   = 1'b0,
  parameter bit BOOT_EN     = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [8*INSTR_BYTES-1:0] rsp_instr,
  output logic                     rsp_fault,
  input  logic                     ld_en,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [7:0]               ld_data,
  output logic                     ld_err
);

  localparam int INSTR_W = instr_w(INSTR_BYTES);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic               rsp_valid_q, rsp_valid_d;
  logic [INSTR_W-1:0] rsp_instr_q, rsp_instr_d;
  logic               rsp_fault_q, rsp_fault_d;
  logic               ld_err_q, ld_err_d;

  logic [ADDR_W:0]    req_addr_x;
  logic [ADDR_W:0]    req_last;
  logic [INSTR_W-1:0] rd_data;
  logic               fault;
  logic               accept;
  logic               ld_in_range;
  logic               ram_we;
  logic               boot;

  // Handshake: a transfer happens on an edge where valid && ready. The request
  // side is ready whenever the response register is empty or being drained;
  // a held response stays stable until rsp_valid && rsp_ready.
  assign req_ready = reset && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;

  assign req_addr_x = {1'b0, req_addr};
  assign req_last   = req_addr_x + (ADDR_W+1)'(INSTR_BYTES - 1);
  assign fault      = (req_last >= DEPTH_X) ||
                      (ALIGN_CHK && ((req_addr_x % (ADDR_W+1)'(INSTR_BYTES)) != '0));

  assign ld_in_range = ({1'b0, ld_addr} < DEPTH_X);
  assign ram_we      = reset && ld_en && ld_in_range;
  assign boot        = BOOT_EN && !reset;

  instr_byte_ram #(
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .INSTR_BYTES (INSTR_BYTES),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk     (clk),
    .boot_i  (boot),
    .we_i    (ram_we),
    .waddr_i (ld_addr[IDX_W-1:0]),
    .wdata_i (ld_data),
    .raddr_i (req_addr_x),
    .rdata_o (rd_data)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_fault_d = rsp_fault_q;
    ld_err_d    = ld_en && !ld_in_range;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_fault_d = fault;
      rsp_instr_d = fault ? {INSTR_BYTES{NOP_INSTR}} : rd_data;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_fault_q <= 1'b0;
      ld_err_q    <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_fault_q <= rsp_fault_d;
      ld_err_q    <= ld_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_fault = rsp_fault_q;
  assign ld_err    = ld_err_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: default instance plus an ALIGN_CHK=1
// instance sharing the same stimulus.
module tb_instr_fetch_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [7:0]  req_addr;
  logic        rsp_ready;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;

  logic        req_ready, rsp_valid, rsp_fault, ld_err;
  logic [31:0] rsp_instr;
  logic        al_req_ready, al_rsp_valid, al_rsp_fault, al_ld_err;
  logic [31:0] al_rsp_instr;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  instr_fetch_mem u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_fault(rsp_fault),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err)
  );

  instr_fetch_mem #(.ALIGN_CHK(1'b1)) u_dut_al (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(al_req_ready), .req_addr(req_addr),
    .rsp_valid(al_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(al_rsp_instr), .rsp_fault(al_rsp_fault),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(al_ld_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare the held response against the oldest expectation
  task automatic check_rsp(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      check(tag, rsp_instr, e);
    end
  endtask

  // drivers: called at a negedge, return at the following negedge
  task automatic fetch(input logic [7:0] addr);
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] addr, input logic [7:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_instr", rsp_instr, 32'd0);
    check("rst_fault", {31'd0, rsp_fault}, 32'd0);
    check("rst_ld_err", {31'd0, ld_err}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    #1 check("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // 1: boot image at address 0
    exp_q.push_back(32'hC51B591B);
    fetch(8'd0);
    check_rsp("fetch0");
    check("fetch0_fault", {31'd0, rsp_fault}, 32'd0);

    // 2: unaligned fetch, allowed by default, faulting with ALIGN_CHK=1
    exp_q.push_back(32'h003B5BC5);
    fetch(8'd3);
    check_rsp("fetch3");
    check("fetch3_fault", {31'd0, rsp_fault}, 32'd0);
    check("fetch3_al_fault", {31'd0, al_rsp_fault}, 32'd1);
    check("fetch3_al_instr", al_rsp_instr, 32'd0);

    // 3: range boundary at DEPTH=36
    exp_q.push_back(32'd0);
    fetch(8'd33);
    check_rsp("fetch33");
    check("fetch33_fault", {31'd0, rsp_fault}, 32'd1);
    fetch(8'd32);
    check("fetch32_valid", {31'd0, rsp_valid}, 32'd1);
    check("fetch32_fault", {31'd0, rsp_fault}, 32'd0);
    @(negedge clk);
    check("drain_valid", {31'd0, rsp_valid}, 32'd0);

    load(8'd7, 8'hAA);
    check("load7_ld_err", {31'd0, ld_err}, 32'd0);

    // 4: backpressure holds the response
    rsp_ready = 1'b0;
    fetch(8'd0);
    for (int i = 0; i < 3; i++) begin
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_instr", rsp_instr, 32'hC51B591B);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", {31'd0, req_ready}, 32'd1);
    exp_q.push_back(32'hAA003B5B);
    fetch(8'd4);
    check_rsp("fetch4");
    @(negedge clk);
    check("fetch4_drain", {31'd0, rsp_valid}, 32'd0);

    // 5: load/fetch collision reads the old byte
    ld_en = 1'b1; ld_addr = 8'd1; ld_data = 8'hFF;
    exp_q.push_back(32'hC51B591B);
    fetch(8'd0);
    ld_en = 1'b0;
    check_rsp("collide_old");
    exp_q.push_back(32'hC51BFF1B);
    fetch(8'd0);
    check_rsp("collide_new");
    load(8'd40, 8'h55);
    check("oob_ld_err", {31'd0, ld_err}, 32'd1);
    @(negedge clk);
    check("oob_ld_err_pulse", {31'd0, ld_err}, 32'd0);
    exp_q.push_back(32'hC51BFF1B);
    fetch(8'd0);
    check_rsp("oob_unchanged");

    // 6: reset drops a held response and restores the boot bytes
    rsp_ready = 1'b0;
    fetch(8'd4);
    check("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
    reset = 1'b0;
    req_valid = 1'b1; req_addr = 8'd0;
    ld_en = 1'b1; ld_addr = 8'd40;
    @(negedge clk);
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_instr", rsp_instr, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_ld_err", {31'd0, ld_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; ld_en = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    exp_q.push_back(32'hC51B591B);
    fetch(8'd0);
    check_rsp("post_rst_boot");
    exp_q.push_back(32'hAA003B5B);
    fetch(8'd4);
    check_rsp("post_rst_keep7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
